async_event_handshake_tx: RTL
=============================

Name: async_event_handshake_tx

Overview:
- Transmit side of a four-phase req/ack event crossing into an asynchronous consumer.
- Counts single-cycle events arriving in the outclk domain and issues one req_out level per event.
- Each req_out is held until the consumer's async_ack returns; async_ack is synchronised internally.
- Used where the N64 controller logic must signal a foreign-clock or unclocked agent, and each event must be delivered exactly once.

Parameters:
- CNT_W, 4, width of the pending-event counter; max pending = 2**CNT_W-1.
- TIMEOUT, 1024, outclk cycles allowed in REQ or RELEASE before abort; 0 disables timeout.

Ports:
- outclk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- event_pulse  in  1  synchronous; one event per cycle high.
- async_ack  in  1  consumer acknowledge, asynchronous to outclk.
- clear_err  in  1  synchronous; clears the sticky error flags.
- req_out  out  1  four-phase request level, registered.
- busy  out  1  high when the FSM is not IDLE or pending != 0.
- pending  out  CNT_W  events accepted but not yet completed, including the one in flight.
- done  out  1  one-cycle strobe when a handshake completes.
- overflow  out  1  sticky: an event was dropped because the counter was saturated.
- timeout_err  out  1  sticky: a handshake was aborted by the timeout.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; sync flops 0; timer 0. Reset mid-handshake drops req_out at once and loses pending events.
- Ack synchroniser: two flops, ack_s1 <= async_ack and ack_s <= ack_s1. The FSM uses ack_s only, giving 2-3 cycles of latency.
- pending update per cycle:
  - +1 on event_pulse.
  - -1 on completion or abort.
  - Both in the same cycle: unchanged.
  - event_pulse at max with no decrement: pending stays, overflow <= 1, event lost.
- FSM:
  - IDLE: if pending != 0, or event_pulse this cycle, go to REQ and req_out <= 1 on the next edge. An event with pending=0 raises req_out 1 cycle after event_pulse.
  - REQ: req_out=1. On ack_s=1 go to RELEASE, req_out <= 0.
  - RELEASE: req_out=0. On ack_s=0 go to IDLE, pulse done, pending -1.
    - If pending-1 != 0, go directly to REQ instead of IDLE (back-to-back events).
    - Back-to-back: req_out rises the cycle after done.
  - ABORT: entered from REQ or RELEASE when timer == TIMEOUT-1.
    - On entry: req_out <= 0, pending -1, timeout_err <= 1, no done.
    - Waits for ack_s=0, then goes to IDLE.
- Timer:
  - Clears on every state change.
  - Increments each cycle in REQ or RELEASE.
  - Unused when TIMEOUT=0.
- Error flags:
  - clear_err clears overflow and timeout_err.
  - A set and clear_err in the same cycle: set wins.
- done and timeout abort are mutually exclusive.
- busy = (state != IDLE) || (pending != 0).
- async_ack already high in IDLE: no action. A new REQ waits for ack_s=1, so a stale high ack completes it. Consumers must return ack low before a new request.

Test Plan:
- Reset, single event: event_pulse at cycle 0 -> req_out=1 at cycle 1, pending=1. Assert async_ack at cycle 5 -> req_out=0 by cycle 8. Drop ack -> done one cycle within 3 cycles, pending=0, busy=0.
- Burst: 3 consecutive event_pulse cycles -> pending=3. Consumer acks each request -> exactly 3 req_out rising edges and 3 done strobes, pending ends at 0, no IDLE gap between handshakes.
- Saturation: CNT_W=2, 5 events with no ack -> pending=3, overflow=1. clear_err -> overflow=0, pending stays 3.
- Timeout: TIMEOUT=16, event with ack never asserted -> req_out falls after 16 cycles in REQ, timeout_err=1, pending=0, done never pulses.
- Simultaneous: event_pulse in the same cycle as completion with pending=1 -> pending stays 1, req_out re-rises next cycle.
- Async reset: assert reset mid-REQ between clock edges -> req_out=0 and pending=0 immediately. After release, the first event behaves as in the single-event case.

Source files
------------

// File: rtl/async_event_handshake_tx.sv
// Transmit side of a four-phase req/ack event crossing: counts outclk-domain events
// and delivers each one exactly once as a req_out level acknowledged by async_ack.
module async_event_handshake_tx #(
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic             outclk,
    input  logic             reset,
    input  logic             event_pulse,
    input  logic             async_ack,
    input  logic             clear_err,
    output logic             req_out,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             done,
    output logic             overflow,
    output logic             timeout_err
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : TMR_ZERO;
    localparam logic [CNT_W-1:0] PEND_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PEND_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        RELEASE = 2'd2,
        ABORT   = 2'd3
    } state_t;

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic             ack_s1;
    logic             ack_s;

    logic             in_hs;
    logic             tmo_hit;
    logic             complete;
    logic             abort_go;
    logic             dec;
    logic             ovf_set;
    logic [CNT_W-1:0] pending_nxt;

    // Two-flop synchroniser for the consumer acknowledge
    always_ff @(posedge outclk or posedge reset) begin
        if (reset) begin
            ack_s1 <= 1'b0;
            ack_s  <= 1'b0;
        end else begin
            ack_s1 <= async_ack;
            ack_s  <= ack_s1;
        end
    end

    // Handshake progress, abort decision and pending-counter next value
    always_comb begin
        in_hs       = (state == REQ) || (state == RELEASE);
        tmo_hit     = (TIMEOUT != 0) && in_hs && (timer == TMR_LAST);
        complete    = (state == RELEASE) && !ack_s;
        // An ack edge arriving on the last timer cycle still wins over the abort.
        abort_go    = tmo_hit && (((state == REQ) && !ack_s) || ((state == RELEASE) && ack_s));
        dec         = complete || abort_go;
        pending_nxt = pending;
        ovf_set     = 1'b0;
        case ({event_pulse, dec})
            2'b10: begin
                if (pending == PEND_MAX) begin
                    pending_nxt = pending;
                    ovf_set     = 1'b1;
                end else begin
                    pending_nxt = pending + PEND_ONE;
                    ovf_set     = 1'b0;
                end
            end
            2'b01: begin
                pending_nxt = pending - PEND_ONE;
            end
            default: begin
                pending_nxt = pending;
            end
        endcase
    end

    // Handshake FSM with registered outputs, counter and sticky error flags
    always_ff @(posedge outclk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= TMR_ZERO;
            req_out     <= 1'b0;
            pending     <= PEND_ZERO;
            done        <= 1'b0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done        <= 1'b0;
            pending     <= pending_nxt;
            overflow    <= ovf_set | (overflow & ~clear_err);
            timeout_err <= abort_go | (timeout_err & ~clear_err);
            case (state)
                IDLE: begin
                    timer <= TMR_ZERO;
                    if ((pending != PEND_ZERO) || event_pulse) begin
                        state   <= REQ;
                        req_out <= 1'b1;
                    end else begin
                        req_out <= 1'b0;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        state   <= RELEASE;
                        req_out <= 1'b0;
                        timer   <= TMR_ZERO;
                    end else if (abort_go) begin
                        state   <= ABORT;
                        req_out <= 1'b0;
                        timer   <= TMR_ZERO;
                    end else begin
                        req_out <= 1'b1;
                        timer   <= (TIMEOUT == 0) ? TMR_ZERO : timer + TMR_ONE;
                    end
                end
                RELEASE: begin
                    if (complete) begin
                        done  <= 1'b1;
                        timer <= TMR_ZERO;
                        // Further work queued: skip IDLE so the next request follows immediately.
                        if (pending_nxt != PEND_ZERO) begin
                            state   <= REQ;
                            req_out <= 1'b1;
                        end else begin
                            state   <= IDLE;
                            req_out <= 1'b0;
                        end
                    end else if (abort_go) begin
                        state   <= ABORT;
                        req_out <= 1'b0;
                        timer   <= TMR_ZERO;
                    end else begin
                        req_out <= 1'b0;
                        timer   <= (TIMEOUT == 0) ? TMR_ZERO : timer + TMR_ONE;
                    end
                end
                ABORT: begin
                    req_out <= 1'b0;
                    timer   <= TMR_ZERO;
                    if (!ack_s) begin
                        state <= IDLE;
                    end else begin
                        state <= ABORT;
                    end
                end
                default: begin
                    state   <= IDLE;
                    req_out <= 1'b0;
                    timer   <= TMR_ZERO;
                end
            endcase
        end
    end

    assign busy = (state != IDLE) || (pending != PEND_ZERO);

endmodule
